// File: rtl/demux_stream_router_pkg.sv
// Shared constants and types for the stream demultiplexer.
package demux_pkg;

  localparam int DEMUX_N_CH = 4;
  localparam int DEMUX_DW   = 8;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_stream_router_if.sv
// Input stream plus the fan of output streams of the router.
interface demux_stream_router_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH)
);

  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_data;
  logic [SELW-1:0]    in_sel;
  logic               in_bcast;
  logic [N_CH-1:0]    out_valid;
  logic [N_CH-1:0]    out_ready;
  logic [N_CH*DW-1:0] out_data;

  // Producer and consumers side.
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Router side.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_stream_router_out_slot.sv
// One-entry output register slice for a single channel.
//
//   state | meaning
//   EMPTY | no beat held, out_valid = 0
//   FULL  | beat held in q, out_valid = 1
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DW = DEMUX_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] q,
  output logic          can_load
);

  slot_state_t state;

  // Slot FSM and data register; q keeps its last value when the slot drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      q     <= '0;
    end else begin
      if (load) begin
        state <= FULL;
        q     <= d;
      end else if (state == FULL && out_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign out_valid = (state == FULL);

  // A full slot being drained this cycle can take a new beat without a bubble.
  assign can_load = !out_valid || out_ready;

endmodule

// File: rtl/demux_stream_router.sv
// Routes one valid/ready stream to one of N_CH registered outputs, or to all.
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int N_CH = DEMUX_N_CH,
  parameter int DW   = DEMUX_DW,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_stream_router_if.slave  bus,
  output logic                  err_sel,
  input  logic                  err_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [N_CH-1:0]    can_load;
  logic [N_CH-1:0]    load;
  logic [N_CH-1:0]    out_valid_w;
  logic [N_CH*DW-1:0] out_data_w;
  logic               sel_ok;
  logic               in_ready_w;
  logic               accept;
  logic               bad_beat;

  // Extra bit keeps N_CH representable when it is a power of two.
  assign sel_ok = ({1'b0, bus.in_sel} < (SELW+1)'(N_CH));

  // Readiness never looks at in_valid; bad selects are always swallowed.
  always_comb begin
    in_ready_w = 1'b0;
    if (bus.in_bcast) begin
      in_ready_w = &can_load;
    end else if (!sel_ok) begin
      in_ready_w = 1'b1;
    end else begin
      in_ready_w = can_load[bus.in_sel];
    end
  end

  assign accept   = bus.in_valid && in_ready_w;
  assign bad_beat = accept && !bus.in_bcast && !sel_ok;

  // Per-channel load strobes; broadcast only accepts when every slot can load.
  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept && (bus.in_bcast || (sel_ok && bus.in_sel == SELW'(k)));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_out_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .d         (bus.in_data),
      .out_ready (bus.out_ready[g]),
      .out_valid (out_valid_w[g]),
      .q         (out_data_w[g*DW +: DW]),
      .can_load  (can_load[g])
    );
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;

  // Sticky select error; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
    end else if (bad_beat) begin
      err_sel <= 1'b1;
    end else if (err_clr) begin
      err_sel <= 1'b0;
    end
  end

  // Saturating count of dropped beats, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bad_beat && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed bench: 4-channel instance for routing, 3-channel instance for bad selects.
module tb_demux_stream_router;

  logic clk;
  logic rst_n;

  logic       a_err, a_clr;
  logic [7:0] a_drop;
  logic       b_err, b_clr;
  logic [7:0] b_drop;

  int vectors;
  int miscompares;

  demux_stream_router_if #(.N_CH(4), .DW(8)) a_if ();
  demux_stream_router_if #(.N_CH(3), .DW(8)) b_if ();

  demux_stream_router #(.N_CH(4), .DW(8)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (a_if.slave),
    .err_sel  (a_err),
    .err_clr  (a_clr),
    .drop_cnt (a_drop)
  );

  demux_stream_router #(.N_CH(3), .DW(8)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b_if.slave),
    .err_sel  (b_err),
    .err_clr  (b_clr),
    .drop_cnt (b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    a_clr       = 1'b0;
    b_clr       = 1'b0;
    a_if.in_valid  = 1'b0;
    a_if.in_data   = '0;
    a_if.in_sel    = '0;
    a_if.in_bcast  = 1'b0;
    a_if.out_ready = 4'b1111;
    b_if.in_valid  = 1'b0;
    b_if.in_data   = '0;
    b_if.in_sel    = '0;
    b_if.in_bcast  = 1'b0;
    b_if.out_ready = 3'b111;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(a_if.out_valid), 32'h0);
    chk("rst_out_data", a_if.out_data, 32'h0);
    chk("rst_err_sel", 32'(a_err), 32'h0);
    chk("rst_drop_cnt", 32'(a_drop), 32'h0);
    #1 rst_n = 1'b1;
    step();

    // Unicast sweep, consumers always ready
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_sel   = 2'(i);
      a_if.in_data  = 8'hA0 + 8'(i);
      #1;
      chk("sweep_in_ready", 32'(a_if.in_ready), 32'h1);
      step();
      chk("sweep_out_valid", 32'(a_if.out_valid), 32'(4'b0001 << i));
      chk("sweep_out_data", 32'(a_if.out_data[i*8 +: 8]), 32'(8'hA0 + 8'(i)));
    end
    a_if.in_valid = 1'b0;
    step();
    chk("sweep_drained", 32'(a_if.out_valid), 32'h0);

    // Backpressure on channel 2
    a_if.out_ready = 4'b1011;
    a_if.in_valid  = 1'b1;
    a_if.in_sel    = 2'd2;
    a_if.in_data   = 8'h11;
    #1;
    chk("bp_first_ready", 32'(a_if.in_ready), 32'h1);
    step();
    chk("bp_first_valid", 32'(a_if.out_valid), 32'h4);
    chk("bp_first_data", 32'(a_if.out_data[23:16]), 32'h11);
    a_if.in_data = 8'h22;
    #1;
    chk("bp_blocked_ready", 32'(a_if.in_ready), 32'h0);
    step();
    chk("bp_held_valid", 32'(a_if.out_valid), 32'h4);
    chk("bp_held_data", 32'(a_if.out_data[23:16]), 32'h11);
    a_if.out_ready = 4'b1111;
    #1;
    chk("bp_release_ready", 32'(a_if.in_ready), 32'h1);
    step();
    chk("bp_second_valid", 32'(a_if.out_valid), 32'h4);
    chk("bp_second_data", 32'(a_if.out_data[23:16]), 32'h22);
    a_if.in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(a_if.out_valid), 32'h0);

    // Broadcast with channel 1 blocked
    a_if.out_ready = 4'b1101;
    a_if.in_valid  = 1'b1;
    a_if.in_sel    = 2'd1;
    a_if.in_data   = 8'h77;
    step();
    chk("bc_ch1_full", 32'(a_if.out_valid), 32'h2);
    a_if.in_bcast = 1'b1;
    a_if.in_data  = 8'h5A;
    #1;
    chk("bc_blocked_ready", 32'(a_if.in_ready), 32'h0);
    step();
    chk("bc_no_load_valid", 32'(a_if.out_valid), 32'h2);
    chk("bc_no_load_ch1", 32'(a_if.out_data[15:8]), 32'h77);
    chk("bc_no_load_ch0", 32'(a_if.out_data[7:0]), 32'hA0);
    a_if.out_ready = 4'b1111;
    #1;
    chk("bc_release_ready", 32'(a_if.in_ready), 32'h1);
    step();
    chk("bc_all_valid", 32'(a_if.out_valid), 32'hF);
    chk("bc_all_data", a_if.out_data, 32'h5A5A5A5A);
    a_if.in_valid = 1'b0;
    a_if.in_bcast = 1'b0;
    step();
    chk("bc_drained", 32'(a_if.out_valid), 32'h0);
    chk("bc_data_kept", a_if.out_data, 32'h5A5A5A5A);

    // Async reset with channels 0 and 3 full
    a_if.out_ready = 4'b0000;
    a_if.in_valid  = 1'b1;
    a_if.in_sel    = 2'd0;
    a_if.in_data   = 8'hC0;
    step();
    a_if.in_sel  = 2'd3;
    a_if.in_data = 8'hC3;
    step();
    a_if.in_valid = 1'b0;
    chk("ar_pre_valid", 32'(a_if.out_valid), 32'h9);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_cleared", 32'(a_if.out_valid), 32'h0);
    chk("ar_data_cleared", a_if.out_data, 32'h0);
    #1 rst_n = 1'b1;
    a_if.out_ready = 4'b1111;
    step();
    a_if.in_valid = 1'b1;
    a_if.in_sel   = 2'd3;
    a_if.in_data  = 8'hD3;
    #1;
    chk("ar_post_ready", 32'(a_if.in_ready), 32'h1);
    step();
    a_if.in_valid = 1'b0;
    chk("ar_post_valid", 32'(a_if.out_valid), 32'h8);
    chk("ar_post_data", 32'(a_if.out_data[31:24]), 32'hD3);

    // Invalid select on the 3-channel instance
    b_if.in_valid = 1'b1;
    b_if.in_sel   = 2'd3;
    b_if.in_data  = 8'hEE;
    #1;
    chk("bad_in_ready", 32'(b_if.in_ready), 32'h1);
    step();
    step();
    step();
    chk("bad_no_valid", 32'(b_if.out_valid), 32'h0);
    chk("bad_err_set", 32'(b_err), 32'h1);
    chk("bad_drop_3", 32'(b_drop), 32'h3);
    b_clr = 1'b1;
    step();
    chk("bad_clr_vs_set", 32'(b_err), 32'h1);
    chk("bad_drop_4", 32'(b_drop), 32'h4);
    b_if.in_valid = 1'b0;
    step();
    b_clr = 1'b0;
    chk("bad_cleared", 32'(b_err), 32'h0);
    chk("bad_drop_kept", 32'(b_drop), 32'h4);
    b_if.in_valid = 1'b1;
    b_if.in_sel   = 2'd2;
    b_if.in_data  = 8'h42;
    step();
    chk("good_after_bad_valid", 32'(b_if.out_valid), 32'h4);
    chk("good_after_bad_data", 32'(b_if.out_data[23:16]), 32'h42);
    chk("good_no_err", 32'(b_err), 32'h0);

    // Drop counter saturation
    b_if.in_sel = 2'd3;
    for (int i = 0; i < 300; i++) step();
    b_if.in_valid = 1'b0;
    chk("sat_drop_cnt", 32'(b_drop), 32'hFF);
    chk("sat_err_sel", 32'(b_err), 32'h1);
    step();
    chk("sat_no_valid", 32'(b_if.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
